// File: rtl/mul_pkg.sv
// Shared types and helpers for the multi-cycle multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_ITER = 2'd1,
    FINISH   = 2'd2
  } mul_state_e;

  function automatic logic is_high_op(input mul_op_e op);
    return op != MUL;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: acc + ((mag_a * bits) << (pos * BITS_PER_CYCLE)).
module mul_step #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 2,
  parameter int unsigned CNT_W          = 5
) (
  input  logic [2*WIDTH-1:0]        i_acc,
  input  logic [WIDTH-1:0]          i_mag_a,
  input  logic [BITS_PER_CYCLE-1:0] i_bits,
  input  logic [CNT_W-1:0]          i_pos,
  output logic [2*WIDTH-1:0]        o_acc
);

  logic [WIDTH+BITS_PER_CYCLE-1:0] w_pp;
  logic [2*WIDTH-1:0]              w_pp_shifted;

  always_comb begin
    w_pp         = (WIDTH+BITS_PER_CYCLE)'(i_mag_a) * (WIDTH+BITS_PER_CYCLE)'(i_bits);
    w_pp_shifted = (2*WIDTH)'(w_pp) << (i_pos * BITS_PER_CYCLE);
    o_acc        = i_acc + w_pp_shifted;
  end

endmodule

// File: rtl/mul_multicycle_param.sv
// Multi-cycle RV32M-style multiplier (MUL/MULH/MULHSU/MULHU) with req/ack/busy handshake.
module mul_multicycle_param
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             ack,
  output logic             busy
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(N + 1);

  mul_state_e         r_state;
  mul_op_e            r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_out;
  logic               r_ack;

  mul_op_e            w_op;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;

  assign w_op     = mul_op_e'(op);
  assign w_sign_a = ((w_op == MULH) || (w_op == MULHSU)) && a[WIDTH-1];
  assign w_sign_b = (w_op == MULH) && b[WIDTH-1];
  assign w_prod   = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;

  assign out  = r_out;
  assign ack  = r_ack;
  assign busy = (r_state != IDLE);

  // Multiplier magnitude shifts right each iteration, so the step always sees its low bits.
  mul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .CNT_W          (CNT_W)
  ) u_step (
    .i_acc   (r_acc),
    .i_mag_a (r_mag_a),
    .i_bits  (r_mag_b[BITS_PER_CYCLE-1:0]),
    .i_pos   (r_cnt),
    .o_acc   (w_acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= MUL;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_ack    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_op     <= w_op;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_mag_a  <= w_sign_a ? -a : a;
            r_mag_b  <= w_sign_b ? -b : b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= MUL_ITER;
          end
        end
        MUL_ITER: begin
          r_acc   <= w_acc_next;
          r_mag_b <= r_mag_b >> BITS_PER_CYCLE;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(N - 1)) r_state <= FINISH;
        end
        FINISH: begin
          r_out   <= is_high_op(r_op) ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
          r_ack   <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_multicycle_param.md
# mul_multicycle_param

Parametrised multi-cycle integer multiplier for the integer execute unit. It covers all four RV32M multiply variants: MUL, MULH, MULHSU and MULHU. The block builds the full 2·WIDTH product BITS_PER_CYCLE bits per clock, then returns either the low or the high half. A single req/ack handshake with a busy flag lets the issue stage hold off new work.

## Interface
- WIDTH, 32: operand and result width in bits; must be a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 2: multiplier bits consumed per iteration; power of two, 1..WIDTH.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- req  input  1  start request; sampled only when busy=0.
- op  input  2  0=MUL (low half), 1=MULH (s×s, high), 2=MULHSU (s×u, high), 3=MULHU (u×u, high).
- a  input  WIDTH  multiplicand (rs1).
- b  input  WIDTH  multiplier (rs2).
- out  output  WIDTH  result; held until the next ack.
- ack  output  1  one-cycle pulse; out is valid while ack=1.
- busy  output  1  high while an operation is in flight.

## Operation
- Reset values: out=0, ack=0, busy=0, state=IDLE, all internal registers 0.
- States:
  - IDLE: on req=1, capture a, b and op. Record per-operand sign flags:
    - a negative if op∈{MULH,MULHSU} and a[WIDTH-1]=1.
    - b negative if op=MULH and b[WIDTH-1]=1.
  - IDLE, continued: store both operands as unsigned magnitudes. Clear the 2·WIDTH accumulator and iteration counter. Go to MUL.
  - MUL: each cycle, add (magnitude_a × next BITS_PER_CYCLE bits of magnitude_b, LSB-first) << position into the accumulator. Increment the counter. After N = WIDTH/BITS_PER_CYCLE iterations, go to FINISH.
  - FINISH: if sign_a XOR sign_b, two's-complement-negate the 2·WIDTH product. Register the low half for MUL, else the high half, into out. Pulse ack=1 and return to IDLE.
- Magnitude of the most-negative value is 2^(WIDTH-1); it fits in WIDTH unsigned bits. There is no overflow special case.
- Negating a zero product yields zero. No special handling is needed.
- Operands and op are captured at acceptance. Input changes afterwards have no effect.
- req while busy=1 is ignored, not queued. The issuer must hold req until it sees the ack.
- rst in any state aborts the operation: no ack, outputs return to reset values on the next edge.
- Width rules: counter is $clog2(N+1) bits. Accumulator is 2·WIDTH bits. The partial product is WIDTH+BITS_PER_CYCLE bits, zero-extended before the shift.

## Timing
- Call the accepting edge E0, where req=1 and busy=0. busy=1 after E0.
- Iterations happen at edges E1..EN. FINISH executes at E(N+1).
- ack=1 and out are valid in the cycle after E(N+1). Total latency is N+1 cycles; for WIDTH=32, BITS_PER_CYCLE=2 that is 17.
- busy=0 during the ack cycle. A req in the ack cycle is accepted at that edge, giving back-to-back throughput of one result per N+1 cycles.
- ack is high for exactly one cycle. out is stable from the ack cycle until the next ack.
- Critical path: one WIDTH×BITS_PER_CYCLE partial product plus a 2·WIDTH add. The FINISH negate is in a separate cycle so it stays off that path.

## Structure
- Shared package mul_pkg:
  - typedef enum mul_op_e {MUL, MULH, MULHSU, MULHU}.
  - typedef enum mul_state_e {IDLE, MUL_ITER, FINISH}.
  - Helper function is_high_op(op).
- Sub-module mul_step: combinational single iteration. Inputs are accumulator, magnitude_a, BITS_PER_CYCLE multiplier bits and position; output is the next accumulator. It is instantiated once.
- Top module holds the FSM, counter, sign flags, capture registers and result select.

## Test plan
- MUL a=7, b=6 (WIDTH=32, BITS_PER_CYCLE=2) -> out=42, ack exactly 17 cycles after the accepting edge, one-cycle pulse; busy high during the 16 iteration cycles.
- a=b=0xFFFFFFFF -> MUL 0x00000001; MULH 0x00000000; MULHU 0xFFFFFFFE; MULHSU 0xFFFFFFFF.
- a=0x80000000 -> with b=0x80000000, MULH gives 0x40000000; with b=0xFFFFFFFF, MULHSU gives 0x80000000; with b=0x80000000, MUL gives 0x00000000.
- Handshake: req held through busy with changing a/b -> the result uses the values at the accepting edge; req in the ack cycle accepted, second ack 17 cycles later; req pulses mid-operation ignored.
- rst asserted on iteration 5 -> no ack ever; out=0, busy=0 next cycle; a fresh MULHU 3×5 then returns 0 (high half) with normal latency.
- Parameter sweep WIDTH=16, BITS_PER_CYCLE=4 -> latency 5; MULHU 0xFFFF×0xFFFF = 0xFFFE; MULH 0x8000×0x0002 = 0xFFFF; random signed/unsigned vectors against a reference model.
